// File: rtl/core_parallel_to_serial_stream.sv
// Double-buffered parallel-to-serial converter: an ACTIVE word shifts out as beats of
// Lanes elements while a PENDING word waits, so consecutive words stream without a bubble.
module core_parallel_to_serial_stream #(
    parameter int Bits     = 8,
    parameter int Length   = 16,
    parameter int Lanes    = 1,
    parameter bit MsbFirst = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          load_valid_i,
    output logic                          load_ready_o,
    input  logic [Bits-1:0]               load_data_i [Length-1:0],
    input  logic [$clog2(Length+1)-1:0]   load_count_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [Bits*Lanes-1:0]         out_data_o,
    output logic [Lanes-1:0]              out_keep_o,
    output logic                          out_last_o,
    output logic                          busy_o
);

    localparam int CountW = $clog2(Length + 1);
    localparam int BeatW  = $clog2(Length / Lanes + 1);
    localparam int IdxW   = (Length > 1) ? $clog2(Length) : 1;

    logic                act_valid, pend_valid;
    logic [Bits-1:0]     act_word  [Length-1:0];
    logic [Bits-1:0]     pend_word [Length-1:0];
    logic [CountW-1:0]   act_count, pend_count, in_count;
    logic [BeatW-1:0]    act_beat, act_nb, pend_nb;
    logic                beat_fire, last_fire, load_fire, load_keep, to_active, to_pend;

    function automatic logic [BeatW-1:0] beats_for(input logic [CountW-1:0] c);
        return BeatW'((int'(c) + Lanes - 1) / Lanes);
    endfunction

    assign in_count  = (load_count_i > CountW'(Length)) ? CountW'(Length) : load_count_i;
    assign beat_fire = act_valid & out_ready_i;
    assign last_fire = beat_fire & (act_beat == act_nb - BeatW'(1));
    // The slot is free only when nothing is pending, so an accepted load never races a handoff.
    assign load_fire = load_valid_i & ~pend_valid & ~flush_i;
    assign load_keep = load_fire & (in_count != '0);
    assign to_active = load_keep & (~act_valid | last_fire);
    assign to_pend   = load_keep & ~to_active;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_valid  <= 1'b0;
            pend_valid <= 1'b0;
            act_count  <= '0;
            pend_count <= '0;
            act_beat   <= '0;
            act_nb     <= '0;
            pend_nb    <= '0;
        end else if (flush_i) begin
            act_valid  <= 1'b0;
            pend_valid <= 1'b0;
            act_count  <= '0;
            pend_count <= '0;
            act_beat   <= '0;
            act_nb     <= '0;
            pend_nb    <= '0;
        end else begin
            if (last_fire && pend_valid) begin
                act_valid  <= 1'b1;
                act_count  <= pend_count;
                act_nb     <= pend_nb;
                act_beat   <= '0;
                pend_valid <= 1'b0;
                pend_count <= '0;
                pend_nb    <= '0;
            end else if (to_active) begin
                act_valid <= 1'b1;
                act_count <= in_count;
                act_nb    <= beats_for(in_count);
                act_beat  <= '0;
            end else if (last_fire) begin
                act_valid <= 1'b0;
                act_count <= '0;
                act_nb    <= '0;
                act_beat  <= '0;
            end else if (beat_fire) begin
                act_beat <= act_beat + BeatW'(1);
            end

            if (to_pend) begin
                pend_valid <= 1'b1;
                pend_count <= in_count;
                pend_nb    <= beats_for(in_count);
            end
        end
    end

    // NOTE: word storage has no reset; the valid flags gate every use, so clearing it buys nothing.
    always_ff @(posedge clk_i) begin
        if (last_fire && pend_valid) begin
            act_word <= pend_word;
        end else if (to_active) begin
            act_word <= load_data_i;
        end
        if (to_pend) begin
            pend_word <= load_data_i;
        end
    end

    always_comb begin
        int e;
        int idx;
        e          = 0;
        idx        = 0;
        out_data_o = '0;
        out_keep_o = '0;
        if (act_valid) begin
            for (int j = 0; j < Lanes; j++) begin
                e = int'(act_beat) * Lanes + j;
                if (e < int'(act_count)) begin
                    idx = MsbFirst ? (Length - 1 - e) : e;
                    out_data_o[j*Bits +: Bits] = act_word[IdxW'(idx)];
                    out_keep_o[j]              = 1'b1;
                end
            end
        end
    end

    assign out_valid_o  = act_valid;
    assign out_last_o   = act_valid & (act_beat == act_nb - BeatW'(1));
    assign busy_o       = act_valid | pend_valid;
    assign load_ready_o = ~pend_valid;

endmodule

// File: tb/tb_core_parallel_to_serial_stream.sv
// Bench for core_parallel_to_serial_stream: three parameterisations share one stimulus stream
// and are checked every cycle against a word-queue model, plus literal beat expectations.
module tb_core_parallel_to_serial_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       ld_valid;
    logic [7:0] ld_data [3:0];
    logic [2:0] ld_count;
    logic       out_ready;

    wire [2:0]  o_ready, o_valid, o_last, o_busy;
    wire [7:0]  data_a, data_c;
    wire [15:0] data_b;
    wire        keep_a, keep_c;
    wire [1:0]  keep_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // a: Lanes=1 LSB-first, b: Lanes=2 LSB-first, c: Lanes=1 MSB-first
    core_parallel_to_serial_stream #(.Bits(8), .Length(4), .Lanes(1), .MsbFirst(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .load_valid_i(ld_valid),
        .load_ready_o(o_ready[0]), .load_data_i(ld_data), .load_count_i(ld_count),
        .out_valid_o(o_valid[0]), .out_ready_i(out_ready), .out_data_o(data_a),
        .out_keep_o(keep_a), .out_last_o(o_last[0]), .busy_o(o_busy[0]));

    core_parallel_to_serial_stream #(.Bits(8), .Length(4), .Lanes(2), .MsbFirst(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .load_valid_i(ld_valid),
        .load_ready_o(o_ready[1]), .load_data_i(ld_data), .load_count_i(ld_count),
        .out_valid_o(o_valid[1]), .out_ready_i(out_ready), .out_data_o(data_b),
        .out_keep_o(keep_b), .out_last_o(o_last[1]), .busy_o(o_busy[1]));

    core_parallel_to_serial_stream #(.Bits(8), .Length(4), .Lanes(1), .MsbFirst(1'b1)) dut_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .load_valid_i(ld_valid),
        .load_ready_o(o_ready[2]), .load_data_i(ld_data), .load_count_i(ld_count),
        .out_valid_o(o_valid[2]), .out_ready_i(out_ready), .out_data_o(data_c),
        .out_keep_o(keep_c), .out_last_o(o_last[2]), .busy_o(o_busy[2]));

    function automatic logic [15:0] dat_of(input int d);
        case (d)
            0:       return {8'h00, data_a};
            1:       return data_b;
            default: return {8'h00, data_c};
        endcase
    endfunction

    function automatic logic [1:0] keep_of(input int d);
        case (d)
            0:       return {1'b0, keep_a};
            1:       return keep_b;
            default: return {1'b0, keep_c};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each DUT holds an ordered list of at most two words; the head streams beats.
    int         m_n    [3];
    logic [7:0] m_w    [3][2][4];
    int         m_cnt  [3][2];
    int         m_beat [3][2];

    logic [15:0] e_dat;
    logic [1:0]  e_keep;
    logic        e_last;
    int          lanes, nb, el, cc;
    bit          msb, acc;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_n[d] = 0;
                check($sformatf("d%0d rst valid", d), 32'(o_valid[d]), 0);
                check($sformatf("d%0d rst last", d), 32'(o_last[d]), 0);
                check($sformatf("d%0d rst busy", d), 32'(o_busy[d]), 0);
                check($sformatf("d%0d rst ready", d), 32'(o_ready[d]), 1);
                check($sformatf("d%0d rst data", d), 32'(dat_of(d)), 0);
                check($sformatf("d%0d rst keep", d), 32'(keep_of(d)), 0);
            end else begin
                lanes  = (d == 1) ? 2 : 1;
                msb    = (d == 2);
                e_dat  = '0;
                e_keep = '0;
                e_last = 1'b0;
                nb     = 0;
                if (m_n[d] > 0) begin
                    nb = (m_cnt[d][0] + lanes - 1) / lanes;
                    for (int j = 0; j < lanes; j++) begin
                        el = m_beat[d][0] * lanes + j;
                        if (el < m_cnt[d][0]) begin
                            e_dat[j*8 +: 8] = m_w[d][0][msb ? 3 - el : el];
                            e_keep[j]       = 1'b1;
                        end
                    end
                    e_last = (m_beat[d][0] == nb - 1);
                end
                check($sformatf("d%0d valid", d), 32'(o_valid[d]), 32'(m_n[d] > 0));
                check($sformatf("d%0d busy", d), 32'(o_busy[d]), 32'(m_n[d] > 0));
                check($sformatf("d%0d ready", d), 32'(o_ready[d]), 32'(m_n[d] < 2));
                check($sformatf("d%0d last", d), 32'(o_last[d]), 32'(e_last));
                if (m_n[d] > 0) begin
                    check($sformatf("d%0d data", d), 32'(dat_of(d)), 32'(e_dat));
                    check($sformatf("d%0d keep", d), 32'(keep_of(d)), 32'(e_keep));
                end

                if (flush) begin
                    m_n[d] = 0;
                end else begin
                    acc = ld_valid && (m_n[d] < 2);
                    cc  = (ld_count > 3'd4) ? 4 : int'(ld_count);
                    if (m_n[d] > 0 && out_ready) begin
                        m_beat[d][0]++;
                        if (m_beat[d][0] == nb) begin
                            m_w[d][0]    = m_w[d][1];
                            m_cnt[d][0]  = m_cnt[d][1];
                            m_beat[d][0] = m_beat[d][1];
                            m_n[d]--;
                        end
                    end
                    if (acc && cc != 0) begin
                        for (int k = 0; k < 4; k++) m_w[d][m_n[d]][k] = ld_data[k];
                        m_cnt[d][m_n[d]]  = cc;
                        m_beat[d][m_n[d]] = 0;
                        m_n[d]++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, b, c, e, input logic [2:0] n);
        ld_data[0] = a;
        ld_data[1] = b;
        ld_data[2] = c;
        ld_data[3] = e;
        ld_count   = n;
        ld_valid   = 1'b1;
        step();
        ld_valid   = 1'b0;
    endtask

    initial begin
        int beats;
        int lasts;
        rst       = 1'b1;
        flush     = 1'b0;
        ld_valid  = 1'b0;
        ld_count  = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) ld_data[k] = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // Single word, full count, consumer always ready
        out_ready = 1'b1;
        load(8'h11, 8'h22, 8'h33, 8'h44, 3'd4);
        check("T1 a valid", 32'(o_valid[0]), 1);
        check("T1 a beat0", 32'(data_a), 32'h11);
        check("T1 a last0", 32'(o_last[0]), 0);
        check("T1 b beat0", 32'(data_b), 32'h2211);
        check("T1 b keep0", 32'(keep_b), 32'h3);
        check("T1 c beat0", 32'(data_c), 32'h44);
        step();
        check("T1 a beat1", 32'(data_a), 32'h22);
        check("T1 b beat1", 32'(data_b), 32'h4433);
        check("T1 b last1", 32'(o_last[1]), 1);
        check("T1 c beat1", 32'(data_c), 32'h33);
        step();
        check("T1 b done", 32'(o_valid[1]), 0);
        check("T1 a beat2", 32'(data_a), 32'h33);
        step();
        check("T1 a beat3", 32'(data_a), 32'h44);
        check("T1 a last3", 32'(o_last[0]), 1);
        check("T1 c beat3", 32'(data_c), 32'h11);
        check("T1 c last3", 32'(o_last[2]), 1);
        step();
        check("T1 a idle", 32'(o_valid[0]), 0);
        check("T1 a busy", 32'(o_busy[0]), 0);

        // Partial last beat on two lanes
        load(8'hA0, 8'hA1, 8'hA2, 8'hA3, 3'd3);
        check("T2 b beat0", 32'(data_b), 32'hA1A0);
        check("T2 b keep0", 32'(keep_b), 32'h3);
        check("T2 b last0", 32'(o_last[1]), 0);
        step();
        check("T2 b beat1", 32'(data_b), 32'h00A2);
        check("T2 b keep1", 32'(keep_b), 32'h1);
        check("T2 b last1", 32'(o_last[1]), 1);
        repeat (3) step();

        // MSB-first, count 2
        load(8'h10, 8'h20, 8'h30, 8'h40, 3'd2);
        check("T5 c beat0", 32'(data_c), 32'h40);
        check("T5 a beat0", 32'(data_a), 32'h10);
        step();
        check("T5 c beat1", 32'(data_c), 32'h30);
        check("T5 c last", 32'(o_last[2]), 1);
        step();
        check("T5 c done", 32'(o_valid[2]), 0);

        // Zero count is swallowed
        load(8'h55, 8'h66, 8'h77, 8'h88, 3'd0);
        check("T5 zero busy", 32'(o_busy), 0);
        check("T5 zero valid", 32'(o_valid), 0);

        // Count above Length clamps to Length
        load(8'h01, 8'h02, 8'h03, 8'h04, 3'd7);
        beats = 0;
        lasts = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_valid[0]) beats++;
            if (o_last[0]) lasts = beats;
            step();
        end
        check("T5 clamp beats", 32'(beats), 4);
        check("T5 clamp lastpos", 32'(lasts), 4);

        // Back-to-back words
        load(8'hB0, 8'hB1, 8'hB2, 8'hB3, 3'd4);
        load(8'hC0, 8'hC1, 8'hC2, 8'hC3, 3'd4);
        check("T3 a ready low", 32'(o_ready[0]), 0);
        beats = 0;
        lasts = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_valid[0] && beats == i) beats++;
            if (o_last[0]) lasts++;
            step();
        end
        check("T3 a contiguous", 32'(beats), 7);
        check("T3 a lasts", 32'(lasts), 2);

        // Flush with a pending word, concurrent load refused
        out_ready = 1'b0;
        load(8'hD0, 8'hD1, 8'hD2, 8'hD3, 3'd4);
        load(8'hE0, 8'hE1, 8'hE2, 8'hE3, 3'd4);
        check("T6 pend ready", 32'(o_ready), 0);
        flush    = 1'b1;
        ld_valid = 1'b1;
        step();
        flush    = 1'b0;
        ld_valid = 1'b0;
        check("T6 flush valid", 32'(o_valid), 0);
        check("T6 flush busy", 32'(o_busy), 0);
        check("T6 flush ready", 32'(o_ready), 32'h7);
        check("T6 flush last", 32'(o_last), 0);
        out_ready = 1'b1;
        step();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            ld_valid = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 4; k++) ld_data[k] = 8'($urandom);
            ld_count  = 3'($urandom_range(0, 7));
            out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : 1'(i % 3 == 0);
            flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        ld_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();

        // Asynchronous reset in the middle of a beat
        out_ready = 1'b0;
        load(8'hF1, 8'hF2, 8'hF3, 8'hF4, 3'd4);
        check("T6 pre-rst valid", 32'(o_valid[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        check("T6 async valid", 32'(o_valid), 0);
        check("T6 async busy", 32'(o_busy), 0);
        check("T6 async data", 32'(data_b), 0);
        check("T6 async keep", 32'(keep_b), 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
